mux_21_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one 2:1 mux datapath between requester 0 and requester 1. It holds a grant per requester, drives the mux select, and registers the selected data bit through a flop stage. It sits in front of the shared 1-bit resource, so the plain 2:1 mux and d-flop become a sequenced, fairly shared channel. Grants can be preempted after a bounded hold time.

---
 rtl/mux_21_rr_arbiter_pkg.sv | 13 +
 rtl/mux_21_rr_datapath.sv | 29 ++
 rtl/mux_21_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux_21_rr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_21_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encoding and the default hold limit.
package mux_21_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   localparam int HOLD_MAX_DEF = 4;

endpackage

// File: rtl/mux_21_rr_datapath.sv
// Shared 2:1 data mux with its output flop and a valid flag that marks
// bits captured while a grant was active.
module mux_21_rr_datapath
   import mux_21_rr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] gnt,
   input  logic       sel,
   input  logic [1:0] data_in,
   output logic       data_out,
   output logic       data_valid
);

   logic mux_bit;

   assign mux_bit = sel ? data_in[1] : data_in[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         if (gnt != 2'b00) data_out <= mux_bit;
         data_valid <= (gnt != 2'b00);
      end
   end

endmodule

// File: rtl/mux_21_rr_arbiter.sv
// Round-robin arbiter sharing a 1-bit mux/flop channel between two
// requesters, with a bounded hold time before a waiting competitor preempts.
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | no grant, datapath output holds
// GNT0    | requester 0 owns the channel (sel=0)
// GNT1    | requester 1 owns the channel (sel=1)
module mux_21_rr_arbiter
   import mux_21_rr_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] data_in,
   output logic [1:0] gnt,
   output logic       sel,
   output logic       data_out,
   output logic       data_valid
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic             last, last_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
         last     <= 1'b1;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         last     <= last_nxt;
      end
   end

   // hold_cnt_nxt defaults to 0, which covers IDLE, every state change and
   // the no-competitor wrap at the hold limit.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = '0;
      last_nxt     = last;
      unique case (state)
         ST_IDLE: begin
            case (req)
               2'b01:   state_nxt = ST_GNT0;
               2'b10:   state_nxt = ST_GNT1;
               2'b11:   state_nxt = last ? ST_GNT0 : ST_GNT1;
               default: state_nxt = ST_IDLE;
            endcase
         end
         ST_GNT0: begin
            if (!req[0]) begin
               last_nxt  = 1'b0;
               state_nxt = req[1] ? ST_GNT1 : ST_IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               if (req[1]) begin
                  last_nxt  = 1'b0;
                  state_nxt = ST_GNT1;
               end
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         ST_GNT1: begin
            if (!req[1]) begin
               last_nxt  = 1'b1;
               state_nxt = req[0] ? ST_GNT0 : ST_IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               if (req[0]) begin
                  last_nxt  = 1'b1;
                  state_nxt = ST_GNT0;
               end
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign gnt = {state == ST_GNT1, state == ST_GNT0};
   assign sel = (state == ST_GNT1);

   mux_21_rr_datapath u_datapath (
      .clk        (clk),
      .rst_n      (rst_n),
      .gnt        (gnt),
      .sel        (sel),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

endmodule

// File: tb/tb_mux_21_rr_arbiter.sv
// Directed bench for mux_21_rr_arbiter: a cycle model pushes expected
// outputs to a queue as stimulus is driven; they are popped after each edge.
module tb_mux_21_rr_arbiter;

   localparam int HOLD_MAX = 4;

   typedef struct {
      logic [1:0] gnt;
      logic       sel;
      logic       dout;
      logic       dv;
      int         step;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req;
   logic [1:0] data_in;
   logic [1:0] gnt;
   logic       sel;
   logic       data_out;
   logic       data_valid;

   int tests  = 0;
   int failed = 0;
   int step_no = 0;

   exp_t sb[$];

   // reference model: owner -1 = nobody, held = cycles spent in current grant
   int   m_owner;
   int   m_held;
   int   m_last;
   logic m_dout;
   logic m_dv;

   mux_21_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .data_in    (data_in),
      .gnt        (gnt),
      .sel        (sel),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [1:0] obs, input logic [1:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s step %0d: observed=%b expected=%b", name, step_no, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_dout  = 1'b0;
      m_dv    = 1'b0;
   endtask

   task automatic model_edge(input logic [1:0] r, input logic [1:0] d);
      int x, y;
      if (m_owner >= 0) begin
         m_dout = d[m_owner];
         m_dv   = 1'b1;
      end else begin
         m_dv = 1'b0;
      end
      if (m_owner < 0) begin
         if (r == 2'b11)      begin m_owner = (m_last == 1) ? 0 : 1; m_held = 1; end
         else if (r == 2'b01) begin m_owner = 0; m_held = 1; end
         else if (r == 2'b10) begin m_owner = 1; m_held = 1; end
      end else begin
         x = m_owner;
         y = 1 - x;
         if (!r[x]) begin
            m_last  = x;
            m_owner = r[y] ? y : -1;
            m_held  = 1;
         end else if (m_held == HOLD_MAX) begin
            if (r[y]) begin
               m_last  = x;
               m_owner = y;
            end
            m_held = 1;
         end else begin
            m_held++;
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      e.sel  = (m_owner == 1);
      e.dout = m_dout;
      e.dv   = m_dv;
      e.step = step_no;
      return e;
   endfunction

   // called at a negedge; returns at the following negedge
   task automatic step(input logic [1:0] r, input logic [1:0] d);
      exp_t e;
      step_no++;
      req     = r;
      data_in = d;
      model_edge(r, d);
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      tests++;
      assert (sb.size() > 0) else begin
         failed++;
         $error("FAIL scoreboard_empty step %0d: observed=0 expected=1", step_no);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("gnt",        gnt,                 e.gnt);
         chk("sel",        {1'b0, sel},         {1'b0, e.sel});
         chk("data_out",   {1'b0, data_out},    {1'b0, e.dout});
         chk("data_valid", {1'b0, data_valid},  {1'b0, e.dv});
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_gnt"},  gnt,                2'b00);
      chk({name, "_sel"},  {1'b0, sel},        2'b00);
      chk({name, "_dout"}, {1'b0, data_out},   2'b00);
      chk({name, "_dv"},   {1'b0, data_valid}, 2'b00);
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = 2'b11;
      data_in = 2'b11;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset_hold");
      rst_n = 1'b1;
      step(2'b11, 2'b10);              // tie after reset goes to requester 0
      step(2'b00, 2'b01);
      step(2'b00, 2'b00);

      // single requester 1 with changing data
      step(2'b10, 2'b10);
      step(2'b10, 2'b00);
      step(2'b10, 2'b10);
      step(2'b00, 2'b01);
      step(2'b00, 2'b01);

      // both requesting: 4-cycle alternation, no bubble
      for (int i = 0; i < 12; i++) step(2'b11, 2'($urandom_range(0, 3)));
      step(2'b00, 2'b00);
      step(2'b00, 2'b00);

      // requester 0 alone never gets preempted
      for (int i = 0; i < 10; i++) step(2'b01, 2'($urandom_range(0, 3)));

      // direct handoff from 0 to 1
      step(2'b11, 2'b01);
      step(2'b10, 2'b10);
      step(2'b10, 2'b00);
      step(2'b00, 2'b00);

      // drop coinciding with the timeout
      step(2'b11, 2'b11);
      step(2'b11, 2'b01);
      step(2'b11, 2'b10);
      step(2'b11, 2'b01);
      step(2'b10, 2'b10);
      step(2'b00, 2'b00);

      // random mix
      for (int i = 0; i < 40; i++) step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

      // asynchronous reset while requester 1 holds the grant
      step(2'b00, 2'b00);
      step(2'b10, 2'b11);
      step(2'b10, 2'b10);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      model_reset();
      req = 2'b11;
      @(negedge clk);
      chk_reset_outputs("async_reset_held");
      rst_n = 1'b1;
      step(2'b11, 2'b01);
      step(2'b11, 2'b10);

      tests++;
      assert (sb.size() == 0) else begin
         failed++;
         $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
